// File: rtl/eq_band_mixer.sv
// eq_band_mixer: gain-weighted sum of FIR band accumulators, rounded and saturated to 24-bit stereo PCM.
// Sticky clip_l/clip_r flags are built only when EQ_MIX_CLIP_DETECT_EN is defined.
module eq_band_mixer #(
   parameter int NUM_BANDS = 4,
   parameter int GAIN_W    = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    audio_en,
   input  logic                    fir_done,
   input  logic [48*NUM_BANDS-1:0] l_band_in,
   input  logic [48*NUM_BANDS-1:0] r_band_in,
   input  logic                    gain_wr_en,
   input  logic [3:0]              gain_select,
   input  logic [GAIN_W-1:0]       gain_wr_data,
   output logic [23:0]             l_mix_out,
   output logic [23:0]             r_mix_out,
   output logic                    mix_valid,
   output logic                    busy,
   output logic                    overrun,
   output logic                    clip_l,
   output logic                    clip_r
);
   localparam int ACC_W = 48 + GAIN_W + 1 + $clog2(NUM_BANDS);
   localparam int PW    = 49 + GAIN_W;
   localparam int KW    = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
   localparam int SH    = 14 + GAIN_W;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MAC  = 2'd1;
   localparam logic [1:0] SAT  = 2'd2;
   localparam logic [GAIN_W-1:0] UNITY = {1'b1, {(GAIN_W-1){1'b0}}};
   // Half an output LSB: rounds half toward +inf before the arithmetic shift.
   localparam logic signed [ACC_W-1:0] HALF = {{(ACC_W-SH){1'b0}}, 1'b1, {(SH-1){1'b0}}};

   logic [GAIN_W-1:0]       gain_q      [NUM_BANDS];
   logic [GAIN_W-1:0]       gain_snap_q [NUM_BANDS];
   logic signed [47:0]      l_snap_q    [NUM_BANDS];
   logic signed [47:0]      r_snap_q    [NUM_BANDS];
   logic [1:0]              state_q, state_d;
   logic [KW-1:0]           k_q, k_d;
   logic signed [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
   logic [23:0]             l_out_q, l_out_d, r_out_q, r_out_d;
   logic                    valid_q, valid_d, ovr_q, ovr_d;
   logic signed [PW-1:0]    prod_l, prod_r;
   logic signed [ACC_W-1:0] rnd_l, rnd_r;
   logic                    ok_l, ok_r, capture;
   logic [23:0]             sat_l, sat_r;

   assign busy    = (state_q != IDLE) || valid_q;
   assign capture = (state_q == IDLE) && fir_done && audio_en;
   assign prod_l  = PW'(l_snap_q[k_q]) * PW'($signed({1'b0, gain_snap_q[k_q]}));
   assign prod_r  = PW'(r_snap_q[k_q]) * PW'($signed({1'b0, gain_snap_q[k_q]}));
   assign rnd_l   = (acc_l_q + HALF) >>> SH;
   assign rnd_r   = (acc_r_q + HALF) >>> SH;
   assign ok_l    = (&rnd_l[ACC_W-1:23]) | ~(|rnd_l[ACC_W-1:23]);
   assign ok_r    = (&rnd_r[ACC_W-1:23]) | ~(|rnd_r[ACC_W-1:23]);
   assign sat_l   = ok_l ? rnd_l[23:0] : (rnd_l[ACC_W-1] ? 24'h800000 : 24'h7FFFFF);
   assign sat_r   = ok_r ? rnd_r[23:0] : (rnd_r[ACC_W-1] ? 24'h800000 : 24'h7FFFFF);

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      acc_l_d = acc_l_q;
      acc_r_d = acc_r_q;
      l_out_d = l_out_q;
      r_out_d = r_out_q;
      valid_d = 1'b0;
      ovr_d   = ovr_q | (fir_done & busy);
      if (capture) begin
         state_d = MAC;
         k_d     = '0;
         acc_l_d = '0;
         acc_r_d = '0;
      end else if (state_q == MAC) begin
         acc_l_d = acc_l_q + ACC_W'(prod_l);
         acc_r_d = acc_r_q + ACC_W'(prod_r);
         k_d     = k_q + KW'(1);
         state_d = (k_q == KW'(NUM_BANDS - 1)) ? SAT : MAC;
      end else if (state_q == SAT) begin
         l_out_d = sat_l;
         r_out_d = sat_r;
         valid_d = 1'b1;
         state_d = IDLE;
      end
      if (!audio_en) begin
         state_d = IDLE;
         l_out_d = '0;
         r_out_d = '0;
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         acc_l_q <= '0;
         acc_r_q <= '0;
         l_out_q <= '0;
         r_out_q <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         acc_l_q <= acc_l_d;
         acc_r_q <= acc_r_d;
         l_out_q <= l_out_d;
         r_out_q <= r_out_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   // Gains survive audio_en=0; snapshots need no reset since they are always loaded before use.
   always_ff @(posedge clk) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
         if (!reset_n)
            gain_q[b] <= UNITY;
         else if (gain_wr_en && gain_select == 4'(b))
            gain_q[b] <= gain_wr_data;
         if (capture) begin
            gain_snap_q[b] <= gain_q[b];
            l_snap_q[b]    <= l_band_in[48*b +: 48];
            r_snap_q[b]    <= r_band_in[48*b +: 48];
         end
      end
   end

`ifdef EQ_MIX_CLIP_DETECT_EN
   logic clip_l_q, clip_r_q;

   always_ff @(posedge clk) begin
      if (!reset_n || !audio_en) begin
         clip_l_q <= 1'b0;
         clip_r_q <= 1'b0;
      end else if (state_q == SAT) begin
         clip_l_q <= clip_l_q | ~ok_l;
         clip_r_q <= clip_r_q | ~ok_r;
      end
   end

   assign clip_l = clip_l_q;
   assign clip_r = clip_r_q;
`else
   assign clip_l = 1'b0;
   assign clip_r = 1'b0;
`endif

   assign l_mix_out = l_out_q;
   assign r_mix_out = r_out_q;
   assign mix_valid = valid_q;
   assign overrun   = ovr_q;
endmodule

// File: tb/tb_eq_band_mixer.sv
// tb_eq_band_mixer: directed vectors for eq_band_mixer; expected samples go through a scoreboard queue
// that a negedge monitor drains whenever mix_valid is seen.
module tb_eq_band_mixer;
   localparam int NB = 4;
`ifdef EQ_MIX_CLIP_DETECT_EN
   localparam logic CLIP_EN = 1'b1;
`else
   localparam logic CLIP_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset_n, audio_en, fir_done, gain_wr_en;
   logic [48*NB-1:0] l_band_in, r_band_in;
   logic [3:0]      gain_select;
   logic [7:0]      gain_wr_data;
   logic [23:0]     l_mix_out, r_mix_out;
   logic            mix_valid, busy, overrun, clip_l, clip_r;

   int              errors = 0;
   int              checks = 0;
   logic [47:0]     exp_q [$];
   logic [47:0]     e;

   eq_band_mixer #(.NUM_BANDS(NB), .GAIN_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .audio_en(audio_en), .fir_done(fir_done),
      .l_band_in(l_band_in), .r_band_in(r_band_in), .gain_wr_en(gain_wr_en),
      .gain_select(gain_select), .gain_wr_data(gain_wr_data),
      .l_mix_out(l_mix_out), .r_mix_out(r_mix_out), .mix_valid(mix_valid),
      .busy(busy), .overrun(overrun), .clip_l(clip_l), .clip_r(clip_r)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input longint act, input longint expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   always @(negedge clk) begin
      if (mix_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got l=%0d r=%0d expected no sample",
                     $signed(l_mix_out), $signed(r_mix_out));
         end else begin
            e = exp_q.pop_front();
            check("mix_l", $signed(l_mix_out), $signed(e[47:24]));
            check("mix_r", $signed(r_mix_out), $signed(e[23:0]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_bands();
      l_band_in = '0;
      r_band_in = '0;
   endtask

   task automatic setb(input int b, input logic [47:0] l, input logic [47:0] r);
      l_band_in[48*b +: 48] = l;
      r_band_in[48*b +: 48] = r;
   endtask

   task automatic wg(input logic [3:0] sel, input logic [7:0] d);
      gain_select  = sel;
      gain_wr_data = d;
      gain_wr_en   = 1'b1;
      tick();
      gain_wr_en   = 1'b0;
   endtask

   task automatic pulse();
      fir_done = 1'b1;
      tick();
      fir_done = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: got %0d samples pending expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) tick();
   endtask

   // Inputs are scrambled after capture so the result must come from the snapshot.
   task automatic sample(input int el, input int er);
      exp_q.push_back({el[23:0], er[23:0]});
      pulse();
      l_band_in = ~l_band_in;
      r_band_in = ~r_band_in;
      drain();
      l_band_in = ~l_band_in;
      r_band_in = ~r_band_in;
   endtask

   initial begin
      reset_n = 1'b0; audio_en = 1'b1; fir_done = 1'b0; gain_wr_en = 1'b0;
      gain_select = '0; gain_wr_data = '0;
      clear_bands();
      repeat (3) tick();
      check("rst_l", l_mix_out, 0);
      check("rst_r", r_mix_out, 0);
      check("rst_valid", mix_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_clip_l", clip_l, 0);
      reset_n = 1'b1;
      tick();

      // single band at unity, with latency and busy window
      setb(0, 48'(1000 * 32768), 48'(0));
      exp_q.push_back({24'd1000, 24'd0});
      pulse();
      check("busy_start", busy, 1);
      l_band_in = ~l_band_in;
      repeat (4) tick();
      check("valid_early", mix_valid, 0);
      tick();
      check("valid_on_time", mix_valid, 1);
      check("busy_at_valid", busy, 1);
      tick();
      check("busy_after", busy, 0);
      check("valid_one_cycle", mix_valid, 0);
      check("hold_l", $signed(l_mix_out), 1000);
      drain();

      clear_bands();
      for (int b = 0; b < NB; b++) setb(b, 48'(100 * 32768), 48'(-200 * 32768));
      sample(400, -800);

      wg(4'd0, 8'h40);
      clear_bands();
      setb(0, 48'(1001 * 32768), 48'(-1001 * 32768));
      sample(501, -500);
      setb(0, 48'(-1001 * 32768), 48'(1001 * 32768));
      sample(-500, 501);

      for (int b = 0; b < NB; b++) wg(4'(b), 8'hFF);
      for (int b = 0; b < NB; b++) setb(b, 48'h7FFF_FFFF_FFFF, 48'h8000_0000_0000);
      sample(8388607, -8388608);
      check("clip_l_set", clip_l, CLIP_EN);
      check("clip_r_set", clip_r, CLIP_EN);

      clear_bands();
      setb(0, 48'(100 * 32768), 48'(0));
      sample(199, 0);
      check("clip_l_sticky", clip_l, CLIP_EN);

      // second fir_done at T+2 is ignored; the gain written with it applies to the next sample
      for (int b = 0; b < NB; b++) wg(4'(b), 8'h80);
      clear_bands();
      setb(1, 48'(1000 * 32768), 48'(0));
      exp_q.push_back({24'd1000, 24'd0});
      pulse();
      tick();
      setb(1, 48'(7 * 32768), 48'(0));
      fir_done = 1'b1; gain_select = 4'd1; gain_wr_data = 8'h40; gain_wr_en = 1'b1;
      tick();
      fir_done = 1'b0; gain_wr_en = 1'b0;
      check("overrun_set", overrun, 1);
      drain();
      check("overrun_sticky", overrun, 1);
      setb(1, 48'(1000 * 32768), 48'(0));
      sample(500, 0);

      // reset mid-MAC aborts the sample and restores unity gains
      clear_bands();
      setb(0, 48'(1000 * 32768), 48'(1000 * 32768));
      pulse();
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("abort_l", l_mix_out, 0);
      check("abort_r", r_mix_out, 0);
      check("abort_busy", busy, 0);
      check("abort_overrun", overrun, 0);
      check("abort_valid", mix_valid, 0);
      check("abort_clip_l", clip_l, 0);
      repeat (8) tick();
      wg(4'd7, 8'h10);
      clear_bands();
      setb(1, 48'(1000 * 32768), 48'(0));
      setb(3, 48'(2000 * 32768), 48'(-2000 * 32768));
      sample(3000, -2000);

      // audio_en low clears sequencer and flags but keeps gains
      wg(4'd2, 8'h40);
      clear_bands();
      setb(2, 48'(1000 * 32768), 48'(0));
      pulse();
      fir_done = 1'b1;
      tick();
      fir_done = 1'b0;
      check("overrun_mac", overrun, 1);
      audio_en = 1'b0;
      tick();
      audio_en = 1'b1;
      check("aen_overrun", overrun, 0);
      check("aen_busy", busy, 0);
      check("aen_l", l_mix_out, 0);
      check("aen_valid", mix_valid, 0);
      repeat (8) tick();
      sample(500, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
